usb_tx_packetizer: RTL and testbench

Parametrised USB-style transmit packetizer and the successor to the fixed IDLE/CRC1/CRC2 handshake test FSM. It accepts a byte stream per packet from an upstream source and forwards it over a registered valid/ready link. It appends the CRC16-USB residue as two trailing bytes and keeps a configurable-depth history of accepted output beats for FSM-extraction and debug checks. It sits between the packet builder and the PHY-side serializer.

---
 rtl/usb_tx_pkg.sv | 18 +
 rtl/usb_crc16_byte.sv | 22 ++
 rtl/usb_tx_packetizer.sv | 152 +++++++++++++++
 tb/tb_usb_tx_packetizer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packetizer.
// The CRC1/CRC2 states are only reachable when USB_TX_CRC_EN is defined.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC1 = 2'd2,
    CRC2 = 2'd3
  } state_t;

  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_XOROUT = 16'hFFFF;

  localparam int PKT_LEN_W = 10;

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational CRC16-USB step: folds one byte, LSB first, into the running
// reflected CRC register.
module usb_crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] crc_acc;

  always_comb begin
    crc_acc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_acc[0] ^ data[i]) crc_acc = (crc_acc >> 1) ^ CRC16_POLY_R;
      else                      crc_acc = crc_acc >> 1;
    end
    crc_out = crc_acc;
  end

endmodule

// File: rtl/usb_tx_packetizer.sv
// Byte-stream packetizer with registered valid/ready output and beat history.
// Define USB_TX_CRC_EN to append the CRC16-USB residue as two trailing bytes.
module usb_tx_packetizer
  import usb_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_BYTES  = 64,
  parameter int HIST_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send_data,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  output logic                 tx_last,
  input  logic                 tx_ready,
  output logic                 len_err,
  output logic [PKT_LEN_W-1:0] pkt_len,
  output logic [HIST_DEPTH-1:0] buff
);

  state_t                state_reg, state_next;
  logic [DATA_W-1:0]     tx_data_reg, tx_data_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic                  tx_last_reg, tx_last_next;
  logic                  len_err_reg, len_err_next;
  logic [PKT_LEN_W-1:0]  pkt_len_reg, pkt_len_next;
  logic [HIST_DEPTH-1:0] buff_reg;
  logic                  out_free, accept, end_pkt;

`ifdef USB_TX_CRC_EN
  logic [15:0] crc_reg, crc_next, crc_upd;

  usb_crc16_byte u_crc (
    .crc_in  (crc_reg),
    .data    (in_data),
    .crc_out (crc_upd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) crc_reg <= CRC16_INIT;
    else        crc_reg <= crc_next;
  end
`endif

  // in_ready must not depend on in_valid, so it is built from state and the output slot only
  assign out_free = !tx_valid_reg || tx_ready;
  assign in_ready = (state_reg == DATA) && out_free;
  assign accept   = in_valid && in_ready;
  assign end_pkt  = in_last || (pkt_len_reg == PKT_LEN_W'(MAX_BYTES - 1));

  always_comb begin
    state_next    = state_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg && !tx_ready;
    tx_last_next  = tx_last_reg;
    pkt_len_next  = pkt_len_reg;
    len_err_next  = 1'b0;
`ifdef USB_TX_CRC_EN
    crc_next      = crc_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (send_data && out_free) begin
          state_next   = DATA;
          pkt_len_next = '0;
`ifdef USB_TX_CRC_EN
          crc_next     = CRC16_INIT;
`endif
        end
      end
      DATA: begin
        if (accept) begin
          tx_data_next  = in_data;
          tx_valid_next = 1'b1;
          pkt_len_next  = pkt_len_reg + PKT_LEN_W'(1);
          len_err_next  = end_pkt && !in_last;
`ifdef USB_TX_CRC_EN
          tx_last_next  = 1'b0;
          crc_next      = crc_upd;
          if (end_pkt) state_next = CRC1;
`else
          tx_last_next  = end_pkt;
          if (end_pkt) state_next = IDLE;
`endif
        end
      end
`ifdef USB_TX_CRC_EN
      CRC1: begin
        if (out_free) begin
          tx_data_next  = crc_reg[7:0] ^ CRC16_XOROUT[7:0];
          tx_valid_next = 1'b1;
          tx_last_next  = 1'b0;
          state_next    = CRC2;
        end
      end
      CRC2: begin
        if (out_free) begin
          tx_data_next  = crc_reg[15:8] ^ CRC16_XOROUT[15:8];
          tx_valid_next = 1'b1;
          tx_last_next  = 1'b1;
          state_next    = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      tx_last_reg  <= 1'b0;
      len_err_reg  <= 1'b0;
      pkt_len_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      tx_last_reg  <= tx_last_next;
      len_err_reg  <= len_err_next;
      pkt_len_reg  <= pkt_len_next;
    end
  end

  // buff[0] records this cycle's output handshake; older beats shift upward
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) buff_reg[0] <= 1'b0;
    else        buff_reg[0] <= tx_valid_reg && tx_ready;
  end

  for (genvar gi = 1; gi < HIST_DEPTH; gi++) begin : g_hist
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) buff_reg[gi] <= 1'b0;
      else        buff_reg[gi] <= buff_reg[gi-1];
    end
  end

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign tx_last  = tx_last_reg;
  assign len_err  = len_err_reg;
  assign pkt_len  = pkt_len_reg;
  assign buff     = buff_reg;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Randomized self-checking bench for usb_tx_packetizer with a packet-level
// reference model; honours USB_TX_CRC_EN when building expected streams.
module tb_usb_tx_packetizer;

  localparam int DATA_W     = 8;
  localparam int MAX_BYTES  = 9;
  localparam int HIST_DEPTH = 10;
`ifdef USB_TX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       forced;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic send_data = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic tx_ready = 1'b0;
  logic in_ready, tx_valid, tx_last, len_err;
  logic [7:0] tx_data;
  logic [9:0] pkt_len;
  logic [HIST_DEPTH-1:0] buff;

  int checks = 0;
  int failures = 0;

  logic [8:0] in_q[$];
  beat_t      exp_q[$];
  logic [7:0] cur_pkt[$];
  int         out_cyc[$];
  beat_t      out_beats[$];
  logic [HIST_DEPTH-1:0] hist = '0;
  bit         ready_rand = 1'b0;
  bit         valid_rand = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;
  int         cycle = 0;
  int         len_err_seen = 0;
  int         forced_exp = 0;
  int         last_pkt_len = 0;

  usb_tx_packetizer #(
    .DATA_W     (DATA_W),
    .MAX_BYTES  (MAX_BYTES),
    .HIST_DEPTH (HIST_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .send_data (send_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .len_err   (len_err),
    .pkt_len   (pkt_len),
    .buff      (buff)
  );

  always #5 clk = ~clk;

  // Packet model: payload split at in_last or MAX_BYTES, CRC16-USB appended low byte first
  task automatic close_packet(input logic by_last);
    logic [15:0] c;
    beat_t b;
    int n;
    n = cur_pkt.size();
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ cur_pkt[i][k]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    c = c ^ 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b.data   = cur_pkt[i];
      b.last   = !CRC_EN && (i == n - 1);
      b.forced = !by_last && (i == n - 1);
      exp_q.push_back(b);
    end
    if (CRC_EN) begin
      b.data = c[7:0];  b.last = 1'b0; b.forced = 1'b0; exp_q.push_back(b);
      b.data = c[15:8]; b.last = 1'b1; b.forced = 1'b0; exp_q.push_back(b);
    end
    if (!by_last) forced_exp++;
    last_pkt_len = n;
    cur_pkt.delete();
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    in_q.push_back({l, d});
    cur_pkt.push_back(d);
    if (l || cur_pkt.size() == MAX_BYTES) close_packet(l);
  endtask

  // One clock of stimulus plus scoreboard checks of the settled outputs
  task automatic step();
    logic hs_out, hs_in;
    beat_t b;
    @(negedge clk);
    tx_ready  = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    send_data = (in_q.size() != 0);
    if (in_q.size() != 0 && (!valid_rand || $urandom_range(0, 3) != 0)) begin
      in_valid = 1'b1;
      {in_last, in_data} = in_q[0];
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'($urandom);
    end
    #1;
    checks++;
    if (buff !== hist) begin
      failures++;
      $display("FAIL buff_history cycle=%0d actual=%b required=%b", cycle, buff, hist);
    end
    if (prev_stall) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d actual=%b/%h/%b required=1/%h/%b",
                 cycle, tx_valid, tx_data, tx_last, prev_data, prev_last);
      end
    end
    if (len_err === 1'b1) begin
      len_err_seen++;
      checks++;
      if (exp_q.size() == 0 || !exp_q[0].forced || tx_valid !== 1'b1 || tx_data !== exp_q[0].data) begin
        failures++;
        $display("FAIL len_err_position cycle=%0d actual_tx=%h required_forced_byte_at_head", cycle, tx_data);
      end
    end
    hs_out = (tx_valid === 1'b1) && (tx_ready === 1'b1);
    if (hs_out) begin
      checks++;
      b.data = tx_data; b.last = tx_last; b.forced = 1'b0;
      out_beats.push_back(b);
      out_cyc.push_back(cycle);
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat cycle=%0d actual=%h/%b required=none", cycle, tx_data, tx_last);
      end else begin
        if (tx_data !== exp_q[0].data || tx_last !== exp_q[0].last) begin
          failures++;
          $display("FAIL tx_beat cycle=%0d actual=%h/%b required=%h/%b",
                   cycle, tx_data, tx_last, exp_q[0].data, exp_q[0].last);
        end
        void'(exp_q.pop_front());
      end
    end
    hs_in = (in_valid === 1'b1) && (in_ready === 1'b1);
    if (hs_in) void'(in_q.pop_front());
    hist       = {hist[HIST_DEPTH-2:0], hs_out};
    prev_stall = (tx_valid === 1'b1) && (tx_ready === 1'b0);
    prev_data  = tx_data;
    prev_last  = tx_last;
    cycle++;
  endtask

  task automatic run_packets(input string name, input int budget);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (in_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual_pending_in=%0d pending_out=%0d required=0", name, in_q.size(), exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx actual=%b/%b/%h required=0/0/00", tx_valid, tx_last, tx_data);
    end
    checks++;
    if (in_ready !== 1'b0 || len_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b/%b required=0/0", in_ready, len_err);
    end
    checks++;
    if (pkt_len !== 10'd0 || buff !== '0) begin
      failures++;
      $display("FAIL reset_regs actual=%0d/%b required=0/0", pkt_len, buff);
    end
    reset = 1'b1;
    hist = '0;
    prev_stall = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_check_string();
    int ok;
    ready_rand = 1'b0; valid_rand = 1'b0;
    out_cyc.delete(); out_beats.delete();
    for (int i = 1; i <= 9; i++) push_byte(8'(8'h30 + i), i == 9);
    run_packets("check_string", 200);
    checks++;
    if (pkt_len !== 10'd9) begin
      failures++;
      $display("FAIL check_string_pkt_len actual=%0d required=9", pkt_len);
    end
    checks++;
`ifdef USB_TX_CRC_EN
    if (out_beats.size() != 11 || out_beats[9].data !== 8'hC8 || out_beats[9].last !== 1'b0 ||
        out_beats[10].data !== 8'hB4 || out_beats[10].last !== 1'b1) begin
      failures++;
      $display("FAIL check_string_crc actual_beats=%0d required=11 ending C8,B4(last)", out_beats.size());
    end
`else
    if (out_beats.size() != 9 || out_beats[8].data !== 8'h39 || out_beats[8].last !== 1'b1) begin
      failures++;
      $display("FAIL check_string_tail actual_beats=%0d required=9 ending 39(last)", out_beats.size());
    end
`endif
    ok = 1;
    for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] - out_cyc[i-1] != 1) ok = 0;
    checks++;
    if (ok == 0) begin
      failures++;
      $display("FAIL check_string_throughput actual=gap_seen required=one_beat_per_cycle");
    end
  endtask

  task automatic test_backpressure();
    int len;
    ready_rand = 1'b1; valid_rand = 1'b1;
    len_err_seen = 0; forced_exp = 0;
    for (int i = 1; i <= 9; i++) push_byte(8'(8'h30 + i), i == 9);
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, MAX_BYTES);
      for (int i = 0; i < len; i++) push_byte(8'($urandom), i == len - 1);
    end
    run_packets("backpressure", 3000);
    checks++;
    if (pkt_len !== 10'(last_pkt_len)) begin
      failures++;
      $display("FAIL backpressure_pkt_len actual=%0d required=%0d", pkt_len, last_pkt_len);
    end
    checks++;
    if (len_err_seen != forced_exp) begin
      failures++;
      $display("FAIL backpressure_len_err actual=%0d required=%0d", len_err_seen, forced_exp);
    end
  endtask

  task automatic test_forced_end();
    ready_rand = 1'b0; valid_rand = 1'b0;
    len_err_seen = 0; forced_exp = 0;
    for (int i = 0; i < MAX_BYTES + 2; i++) push_byte(8'($urandom), i == MAX_BYTES + 1);
    run_packets("forced_end", 300);
    checks++;
    if (len_err_seen != 1 || forced_exp != 1) begin
      failures++;
      $display("FAIL forced_end_len_err actual=%0d required=1", len_err_seen);
    end
    checks++;
    if (pkt_len !== 10'd2) begin
      failures++;
      $display("FAIL forced_end_pkt_len actual=%0d required=2", pkt_len);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    ready_rand = 1'b0; valid_rand = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'($urandom), i == 7);
    n = 0;
    while (in_q.size() > 5 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (in_q.size() > 5) begin
      failures++;
      $display("FAIL reset_mid_progress actual_accepted=%0d required=3", 8 - in_q.size());
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || buff !== '0 || in_ready !== 1'b0 || pkt_len !== 10'd0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_immediate actual=%b/%b/%b/%0d/%h required=0/0/0/0/00",
               tx_valid, buff, in_ready, pkt_len, tx_data);
    end
    send_data = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_held actual=%b required=0", tx_valid);
      end
    end
    in_q.delete(); exp_q.delete(); cur_pkt.delete();
    hist = '0; prev_stall = 1'b0;
    reset = 1'b1;
    len_err_seen = 0; forced_exp = 0;
    for (int i = 1; i <= 9; i++) push_byte(8'(8'h30 + i), i == 9);
    run_packets("reset_restart", 200);
    checks++;
    if (pkt_len !== 10'd9) begin
      failures++;
      $display("FAIL reset_restart_pkt_len actual=%0d required=9", pkt_len);
    end
  endtask

  task automatic test_back_to_back();
    int n_a, gap;
    ready_rand = 1'b0; valid_rand = 1'b0;
    out_cyc.delete(); out_beats.delete();
    for (int i = 0; i < 5; i++) push_byte(8'($urandom), i == 4);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom), i == 3);
    run_packets("back_to_back", 300);
    n_a = 5 + (CRC_EN ? 2 : 0);
    gap = (out_cyc.size() > n_a) ? out_cyc[n_a] - out_cyc[n_a-1] : -1;
    // the start request is sampled in IDLE, so at most one empty slot separates packets
    checks++;
    if (gap < 1 || gap > 2) begin
      failures++;
      $display("FAIL back_to_back_gap actual=%0d required=1..2", gap);
    end
    checks++;
    if (pkt_len !== 10'd4) begin
      failures++;
      $display("FAIL back_to_back_pkt_len actual=%0d required=4", pkt_len);
    end
  endtask

  initial begin
    test_reset();
    test_check_string();
    test_backpressure();
    test_forced_end();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
